// File: rtl/offchip_mem_slave_2ch_if.sv
// Two-channel off-chip memory bus between a master and offchip_mem_slave_2ch.
// Channel c occupies lane c of every vector: oe/we/DataRdy/err bit c,
// addr bits [7c+6:7c], write/read data bits [8c+7:8c], size bits [4c+3:4c].
//   Mout_oe_ram        : per-channel read request
//   Mout_we_ram        : per-channel write request
//   Mout_addr_ram      : per-channel 7-bit byte address
//   Mout_Wdata_ram     : per-channel write byte
//   Mout_data_ram_size : per-channel write bit count (0..15, >=8 means full byte)
//   M_Rdata_ram        : per-channel read byte, non-zero only in the read ACK cycle
//   M_DataRdy          : per-channel one-cycle completion pulse
//   err_conflict       : per-channel sticky oe+we conflict flag
interface offchip_mem_slave_2ch_if;
  logic [1:0]  Mout_oe_ram;
  logic [1:0]  Mout_we_ram;
  logic [13:0] Mout_addr_ram;
  logic [15:0] Mout_Wdata_ram;
  logic [7:0]  Mout_data_ram_size;
  logic [15:0] M_Rdata_ram;
  logic [1:0]  M_DataRdy;
  logic [1:0]  err_conflict;

  modport master (
    output Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    input  M_Rdata_ram, M_DataRdy, err_conflict
  );

  modport slave (
    input  Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size,
    output M_Rdata_ram, M_DataRdy, err_conflict
  );
endinterface

// File: rtl/offchip_mem_slave_2ch.sv
// Behavioural off-chip byte memory with two independent request channels and
// a preload port.  Each channel runs its own IDLE/RBUSY/WBUSY/ACK sequencer
// with programmable read and write latency; both share one storage array.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset (clears FSMs, flags and array)
//   bus       : channel request/response bundle (slave side)
//   init_we   : preload write strobe, independent of channel activity
//   init_addr : preload array index (ignored when >= MEMSIZE)
//   init_data : preload byte

// Per-channel sequencer.  Writes are committed on the IDLE exit edge, so the
// only request field that has to be held afterwards is the array index the
// read capture uses.
//   oe/we/addr/wdata/size : this channel's request lane
//   rd_byte / rd_idx      : array byte at the held index / that index
//   wr_en/wr_idx/wr_mask/wr_data : write commit for the shared array
//   rdy/rdata/err         : this channel's response lane
module offchip_mem_slave_ch #(
  parameter int MEMSIZE     = 32,
  parameter int BASE_ADDR   = 0,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1,
  parameter int IW          = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          oe,
  input  logic          we,
  input  logic [6:0]    addr,
  input  logic [7:0]    wdata,
  input  logic [3:0]    size,
  input  logic [7:0]    rd_byte,
  output logic [IW-1:0] rd_idx,
  output logic          wr_en,
  output logic [IW-1:0] wr_idx,
  output logic [7:0]    wr_mask,
  output logic [7:0]    wr_data,
  output logic          rdy,
  output logic [7:0]    rdata,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, RBUSY, WBUSY, ACK} state_t;

  localparam logic [3:0] RD_LAT = 4'(READ_DELAY);
  localparam logic [3:0] WR_LAT = 4'(WRITE_DELAY);

  state_t        st_q, st_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [8:0]    off;
  logic          in_rng;

  // Bit 8 of the offset is the borrow: set when addr is below BASE_ADDR.
  assign off    = {2'b00, addr} - 9'(BASE_ADDR);
  assign in_rng = !off[8] && (off[7:0] < 8'(MEMSIZE));

  // Low 'size' bits come from the request, the rest keep the old byte.
  assign wr_mask = size[3] ? 8'hFF : ~(8'hFF << size[2:0]);
  assign wr_data = wdata;
  assign wr_idx  = off[IW-1:0];

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rdata_d = '0;
    err_d   = err_q;
    wr_en   = 1'b0;
    case (st_q)
      IDLE: begin
        if (oe && we) begin
          err_d = 1'b1;
        end else if (oe && in_rng) begin
          st_d  = RBUSY;
          cnt_d = 4'd1;
          idx_d = off[IW-1:0];
        end else if (we && in_rng) begin
          st_d  = WBUSY;
          cnt_d = 4'd1;
          idx_d = off[IW-1:0];
          wr_en = 1'b1;
        end
      end
      RBUSY: begin
        if (cnt_q == RD_LAT) begin
          st_d    = ACK;
          rdata_d = rd_byte;   // pre-write value if a commit lands on this edge
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WBUSY: begin
        if (cnt_q == WR_LAT) st_d = ACK;
        else                 cnt_d = cnt_q + 4'd1;
      end
      ACK: begin
        st_d  = IDLE;
        cnt_d = '0;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rd_idx = idx_q;
  assign rdy    = (st_q == ACK);
  assign rdata  = rdata_q;
  assign err    = err_q;
endmodule

module offchip_mem_slave_2ch #(
  parameter int MEMSIZE     = 32,
  parameter int BASE_ADDR   = 0,
  parameter int READ_DELAY  = 2,
  parameter int WRITE_DELAY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  offchip_mem_slave_2ch_if.slave  bus,
  input  logic                    init_we,
  input  logic [6:0]              init_addr,
  input  logic [7:0]              init_data
);
  localparam int NCH = 2;
  localparam int IW  = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;

  logic [7:0] mem [MEMSIZE];

  logic [NCH-1:0]         wr_en, rdy, err;
  logic [NCH-1:0][IW-1:0] wr_idx, rd_idx;
  logic [NCH-1:0][7:0]    wr_mask, wr_data, rd_byte, rdata;
  logic                   init_ok;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    offchip_mem_slave_ch #(
      .MEMSIZE(MEMSIZE), .BASE_ADDR(BASE_ADDR),
      .READ_DELAY(READ_DELAY), .WRITE_DELAY(WRITE_DELAY), .IW(IW)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .oe      (bus.Mout_oe_ram[c]),
      .we      (bus.Mout_we_ram[c]),
      .addr    (bus.Mout_addr_ram[c*7 +: 7]),
      .wdata   (bus.Mout_Wdata_ram[c*8 +: 8]),
      .size    (bus.Mout_data_ram_size[c*4 +: 4]),
      .rd_byte (rd_byte[c]),
      .rd_idx  (rd_idx[c]),
      .wr_en   (wr_en[c]),
      .wr_idx  (wr_idx[c]),
      .wr_mask (wr_mask[c]),
      .wr_data (wr_data[c]),
      .rdy     (rdy[c]),
      .rdata   (rdata[c]),
      .err     (err[c])
    );
    assign rd_byte[c] = mem[rd_idx[c]];
  end

  assign init_ok = ({1'b0, init_addr} < 8'(MEMSIZE));

  // Later assignments win on a same-byte collision: channel 1 over channel 0,
  // preload over both.  Each merge uses the pre-edge byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MEMSIZE; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (wr_en[i])
          mem[wr_idx[i]] <= (wr_data[i] & wr_mask[i]) | (mem[wr_idx[i]] & ~wr_mask[i]);
      if (init_we && init_ok) mem[init_addr[IW-1:0]] <= init_data;
    end
  end

  assign bus.M_DataRdy    = rdy;
  assign bus.M_Rdata_ram  = rdata;
  assign bus.err_conflict = err;
endmodule

// File: tb/tb_offchip_mem_slave_2ch.sv
// Randomised and directed bench for offchip_mem_slave_2ch (MEMSIZE 32,
// BASE_ADDR 0, read latency 2, write latency 1).  A transaction-level model
// predicts DataRdy / read lane / conflict flags per edge and is compared on
// every falling edge; directed sequences add literal expectations.
module tb_offchip_mem_slave_2ch;
  localparam int MS = 32;
  localparam int BA = 0;
  localparam int RD = 2;
  localparam int WR = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       init_we = 1'b0;
  logic [6:0] init_addr = '0;
  logic [7:0] init_data = '0;

  offchip_mem_slave_2ch_if bus();

  offchip_mem_slave_2ch #(.MEMSIZE(MS), .BASE_ADDR(BA), .READ_DELAY(RD), .WRITE_DELAY(WR)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_data (init_data)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mmem [MS];
  int          edge_n = 0;
  bit          pend [2];
  bit          prd [2];
  int          pidx [2];
  int          ack_e [2];
  int          free_e [2];
  logic [1:0]  exp_rdy = '0;
  logic [1:0]  exp_err = '0;
  logic [15:0] exp_rdata = '0;

  task automatic model_step();
    logic [7:0] nv [2];
    bit         wr [2];
    int         widx [2];
    logic       oe, we;
    int         a;
    logic [7:0] d, m;
    logic [3:0] s;
    edge_n++;
    exp_rdy   = '0;
    exp_rdata = '0;
    for (int c = 0; c < 2; c++) begin
      wr[c] = 0; nv[c] = '0; widx[c] = 0;
      if (pend[c] && ack_e[c] == edge_n) begin
        exp_rdy[c] = 1'b1;
        if (prd[c]) exp_rdata[c*8 +: 8] = mmem[pidx[c]];
        pend[c]   = 0;
        free_e[c] = edge_n + 2;   // ACK cycle, then back to sampling
      end
    end
    for (int c = 0; c < 2; c++) begin
      if (!pend[c] && edge_n >= free_e[c]) begin
        oe = bus.Mout_oe_ram[c];
        we = bus.Mout_we_ram[c];
        a  = int'(bus.Mout_addr_ram[c*7 +: 7]);
        d  = bus.Mout_Wdata_ram[c*8 +: 8];
        s  = bus.Mout_data_ram_size[c*4 +: 4];
        if (oe && we) exp_err[c] = 1'b1;
        else if ((oe || we) && a >= BA && a < BA + MS) begin
          pend[c]  = 1;
          prd[c]   = oe;
          pidx[c]  = a - BA;
          ack_e[c] = edge_n + (oe ? RD : WR);
          if (we) begin
            m       = (s >= 8) ? 8'hFF : 8'((1 << s) - 1);
            wr[c]   = 1;
            widx[c] = a - BA;
            nv[c]   = (d & m) | (mmem[a - BA] & ~m);
          end
        end
      end
    end
    for (int c = 0; c < 2; c++) if (wr[c]) mmem[widx[c]] = nv[c];
    if (init_we && int'(init_addr) < MS) mmem[init_addr] = init_data;
  endtask

  initial begin : model
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        for (int i = 0; i < MS; i++) mmem[i] = '0;
        for (int c = 0; c < 2; c++) begin pend[c] = 0; free_e[c] = 0; end
        exp_rdy = '0; exp_rdata = '0; exp_err = '0;
      end else begin
        model_step();
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clock);
      chk("DataRdy", bus.M_DataRdy, exp_rdy);
      chk("Rdata", bus.M_Rdata_ram, exp_rdata);
      chk("err_conflict", bus.err_conflict, exp_err);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic idle();
    bus.Mout_oe_ram        = '0;
    bus.Mout_we_ram        = '0;
    bus.Mout_addr_ram      = '0;
    bus.Mout_Wdata_ram     = '0;
    bus.Mout_data_ram_size = '0;
    init_we                = 1'b0;
  endtask

  task automatic req(input int ch, input logic oe, input logic we, input logic [6:0] a,
                     input logic [7:0] d, input logic [3:0] s);
    bus.Mout_oe_ram[ch]               = oe;
    bus.Mout_we_ram[ch]               = we;
    bus.Mout_addr_ram[ch*7 +: 7]      = a;
    bus.Mout_Wdata_ram[ch*8 +: 8]     = d;
    bus.Mout_data_ram_size[ch*4 +: 4] = s;
  endtask

  task automatic preload(input logic [6:0] a, input logic [7:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    tick(1);
    init_we = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [6:0] a, output logic [7:0] d);
    bit got;
    got = 0;
    d   = '0;
    req(ch, 1'b1, 1'b0, a, 8'h00, 4'h0);
    tick(1);
    idle();
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (bus.M_DataRdy[ch]) begin
        got = 1;
        d   = bus.M_Rdata_ram[ch*8 +: 8];
      end
      tick(1);
    end
    chk("rd_done", 32'(got), 32'd1);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : stim
    logic [7:0] d;
    int         cnt;
    int         r;
    idle();
    @(negedge clock);
    chk("rst_rdy", bus.M_DataRdy, 2'b00);
    chk("rst_rdata", bus.M_Rdata_ram, 16'h0000);
    chk("rst_err", bus.err_conflict, 2'b00);
    tick(2);
    reset = 1'b1;
    tick(1);

    // read of preloaded byte: pulse only in cycle k+2
    preload(7'd5, 8'hA5);
    req(0, 1'b1, 1'b0, 7'd5, 8'h00, 4'h0);
    tick(1); idle();
    @(negedge clock); chk("rd35_k", bus.M_DataRdy, 2'b00);
    tick(1);
    @(negedge clock); chk("rd35_k1", bus.M_DataRdy, 2'b00);
    tick(1);
    @(negedge clock);
    chk("rd35_rdy", bus.M_DataRdy, 2'b01);
    chk("rd35_data", bus.M_Rdata_ram[7:0], 8'hA5);
    chk("model35_data", exp_rdata[7:0], 8'hA5);
    tick(1);
    @(negedge clock);
    chk("rd35_after", bus.M_DataRdy, 2'b00);
    chk("rd35_lane0", bus.M_Rdata_ram, 16'h0000);
    tick(1);

    // partial write on channel 1
    preload(7'd3, 8'hFF);
    req(1, 1'b0, 1'b1, 7'd3, 8'h3C, 4'd4);
    tick(1); idle();
    @(negedge clock); chk("wr36_k", bus.M_DataRdy, 2'b00);
    tick(1);
    @(negedge clock); chk("wr36_rdy", bus.M_DataRdy, 2'b10);
    chk("model36_mem", mmem[3], 8'hFC);
    tick(1);
    rd(1, 7'd3, d); chk("wr36_byte", d, 8'hFC);

    // same-edge writes, channel 1 wins
    req(0, 1'b0, 1'b1, 7'd7, 8'h11, 4'd8);
    req(1, 1'b0, 1'b1, 7'd7, 8'h22, 4'd8);
    tick(1); idle();
    tick(1);
    @(negedge clock); chk("wr37_rdy", bus.M_DataRdy, 2'b11);
    tick(1);
    rd(0, 7'd7, d); chk("wr37_byte", d, 8'h22);

    // conflict on ch0, ch1 reads the same byte undisturbed
    preload(7'd2, 8'h5A);
    req(0, 1'b1, 1'b1, 7'd2, 8'hEE, 4'd8);
    req(1, 1'b1, 1'b0, 7'd2, 8'h00, 4'd0);
    tick(1); idle();
    @(negedge clock); chk("cf38_err", bus.err_conflict, 2'b01);
    tick(2);
    @(negedge clock);
    chk("cf38_rdy", bus.M_DataRdy, 2'b10);
    chk("cf38_ch1", bus.M_Rdata_ram[15:8], 8'h5A);
    tick(1);
    rd(0, 7'd2, d); chk("cf38_mem", d, 8'h5A);
    chk("cf38_held", bus.err_conflict, 2'b01);

    // out-of-range followed immediately by an in-range read
    req(0, 1'b1, 1'b0, 7'd40, 8'h00, 4'h0);
    tick(1);
    rd(0, 7'd5, d); chk("oor39_next", d, 8'hA5);

    // reset right after a read is issued
    req(0, 1'b1, 1'b0, 7'd5, 8'h00, 4'h0);
    tick(1);
    reset = 1'b0;
    idle();
    @(negedge clock); chk("rst40_rdy", bus.M_DataRdy, 2'b00);
    tick(1);
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.M_DataRdy != 2'b00) cnt++;
      tick(1);
    end
    chk("rst40_nordy", cnt, 0);
    chk("rst40_err", bus.err_conflict, 2'b00);
    rd(0, 7'd5, d); chk("rst40_mem5", d, 8'h00);
    rd(1, 7'd3, d); chk("rst40_mem3", d, 8'h00);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 2; c++) begin
        r = $urandom_range(0, 99);
        req(c, (r < 30) || (r == 99), (r >= 30 && r < 60) || (r == 99),
            7'($urandom_range(0, 39)), 8'($urandom), 4'($urandom_range(0, 15)));
      end
      init_we   = ($urandom_range(0, 7) == 0);
      init_addr = 7'($urandom_range(0, 39));
      init_data = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
      end else begin
        tick(1);
      end
    end
    idle();
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/offchip_mem_slave_2ch.md
OFFCHIP_MEM_SLAVE_2CH -- requirements
Module: offchip_mem_slave_2ch

Interface
REQ-001 SHALL have parameter MEMSIZE, default 32: byte depth of the storage array (1..128).
REQ-002 SHALL have parameter BASE_ADDR, default 0: first byte address served, 7-bit.
REQ-003 SHALL have parameter READ_DELAY, default 2: read latency in cycles (1..15).
REQ-004 SHALL have parameter WRITE_DELAY, default 1: write latency in cycles (1..15).
REQ-005 SHALL have port clock, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port Mout_oe_ram, input, 2 bits: per-channel read request.
REQ-008 SHALL have port Mout_we_ram, input, 2 bits: per-channel write request.
REQ-009 SHALL have port Mout_addr_ram, input, 14 bits: channel 0 address in [6:0], channel 1 in [13:7].
REQ-010 SHALL have port Mout_Wdata_ram, input, 16 bits: channel 0 byte in [7:0], channel 1 in [15:8].
REQ-011 SHALL have port Mout_data_ram_size, input, 8 bits: channel 0 bit count in [3:0], channel 1 in [7:4].
REQ-012 SHALL have port init_we, input, 1 bit: preload write strobe.
REQ-013 SHALL have port init_addr, input, 7 bits: preload array index, 0..MEMSIZE-1.
REQ-014 SHALL have port init_data, input, 8 bits: preload byte.
REQ-015 SHALL have port M_Rdata_ram, output, 16 bits: per-channel read byte, lanes as REQ-010.
REQ-016 SHALL have port M_DataRdy, output, 2 bits: per-channel completion pulse.
REQ-017 SHALL have port err_conflict, output, 2 bits: sticky per-channel oe/we-both-high flag.

Function
REQ-018 SHALL treat a channel address as in range iff BASE_ADDR <= addr < BASE_ADDR+MEMSIZE; array index = addr-BASE_ADDR.
REQ-019 SHALL run one independent FSM per channel: IDLE, RBUSY, WBUSY, ACK; each with a 4-bit latency counter.
REQ-020 IDLE: oe=1, we=0, in range -> RBUSY, counter=1; we=1, oe=0, in range -> WBUSY, counter=1; anything else stays IDLE.
REQ-021 SHALL latch address, write data and size at the IDLE exit edge; later input changes are ignored until ACK.
REQ-022 Write SHALL commit at the IDLE->WBUSY edge: mem = (wdata & mask) | (mem & ~mask), mask = (1<<size)-1 saturating to 8'hFF for size >= 8; size 0 leaves the byte unchanged.
REQ-023 RBUSY/WBUSY: counter == delay -> ACK; else counter+1. Delay 1 goes to ACK on the next edge.
REQ-024 Read data SHALL be the array byte at the RBUSY->ACK edge, registered into the channel lane of M_Rdata_ram.
REQ-025 ACK: M_DataRdy[ch]=1 for exactly one cycle, then IDLE unconditionally; no request is sampled in the ACK cycle.
REQ-026 Resulting timing: request first sampled at edge k; DataRdy high between edges k+READ_DELAY and k+READ_DELAY+1 for reads (WRITE_DELAY for writes).
REQ-027 M_Rdata_ram lane SHALL be 0 outside the read ACK cycle.
REQ-028 Out-of-range request: no access, no DataRdy, lane stays 0, FSM stays IDLE.
REQ-029 oe=1 and we=1 sampled in IDLE: set err_conflict[ch], no access, stay IDLE; flag clears only on reset.
REQ-030 Same-edge writes to the same byte: priority init_we > channel 1 > channel 0.
REQ-031 A read whose capture edge coincides with a write commit to the same byte SHALL return the pre-write value.
REQ-032 init_we SHALL write init_data at init_addr on its edge, ignored if init_addr >= MEMSIZE; it is independent of FSM state.

Reset
REQ-033 While reset=0: FSMs IDLE, counters 0, M_DataRdy=0, M_Rdata_ram=0, err_conflict=0, array cleared to 0.
REQ-034 Reset asserted mid-transaction SHALL abort it with no DataRdy after release; a write committed before reset is lost to the array clear.

Verification
REQ-035 Preload index 5 = 8'hA5, BASE_ADDR=0, ch0 oe, addr 5 from edge k -> M_DataRdy[0]=1 and M_Rdata_ram[7:0]=8'hA5 in cycle k+2 only.
REQ-036 ch1 we, addr 3, Wdata[15:8]=8'h3C, size 4, old byte 8'hFF -> DataRdy[1] pulse in cycle k+1; byte becomes 8'hFC.
REQ-037 Both channels write addr 7 on the same edge (ch0 8'h11, ch1 8'h22, size 8) -> byte 7 = 8'h22; both DataRdy pulse.
REQ-038 ch0 oe and we both high, addr 2 -> err_conflict[0]=1 held, no DataRdy, memory unchanged; ch1 unaffected.
REQ-039 ch0 oe, addr 40 with MEMSIZE=32 -> no DataRdy, lane 0; immediate in-range read then completes normally.
REQ-040 reset=0 in the cycle after a read is issued -> no DataRdy after release; array reads back 0.
